// File: rtl/muldiv_seq_if.sv
// Bundle between the execute stage, the mul/div issue sequencer and the ALU's multi-cycle units.
interface muldiv_seq_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 7;
    localparam int unsigned RD_W = 5;

    logic            ex_valid;
    logic [OP_W-1:0] ex_op;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [RD_W-1:0] ex_rd;
    logic            flush;

    logic [OP_W-1:0] alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            mulstart;
    logic            divstart;
    logic            mulvalid;
    logic            divvalid;
    logic [XLEN-1:0] alu_out;

    logic            stall;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            timeout_err;

    modport master (
        output ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush,
        output mulvalid, divvalid, alu_out,
        input  alu_op, alu_a, alu_b, mulstart, divstart,
        input  stall, wb_valid, wb_rd, wb_data, timeout_err
    );

    modport slave (
        input  ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush,
        input  mulvalid, divvalid, alu_out,
        output alu_op, alu_a, alu_b, mulstart, divstart,
        output stall, wb_valid, wb_rd, wb_data, timeout_err
    );
endinterface

// File: rtl/muldiv_seq.sv
// Issue/writeback sequencer for the ALU's multi-cycle multiplier and divider.
// Holds op/operands, pulses the unit start, stalls until the result returns.
module muldiv_seq #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic         clock,
    input  logic         rst,
    muldiv_seq_if.slave  md
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 7;
    localparam int unsigned RD_W = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [OP_W-1:0]  OP_NOP   = 7'b0001111;
    localparam logic [XLEN-1:0]  INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0]  ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [OP_W-1:0] op_q,    op_d;
    logic [XLEN-1:0] a_q,     a_d;
    logic [XLEN-1:0] b_q,     b_d;
    logic [RD_W-1:0] rd_q,    rd_d;
    logic [XLEN-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic            terr_q,  terr_d;

    logic md_req;
    logic ex_is_div;
    logic div_by_zero;
    logic div_overflow;
    logic unit_valid;
    logic cnt_last;

    // Decode of the incoming op and the RISC-V divide special cases.
    assign md_req       = md.ex_valid & ~md.flush &
                          ((md.ex_op[4:3] == 2'b10) | (md.ex_op[4:3] == 2'b11));
    assign ex_is_div    = ~md.ex_op[3];
    assign div_by_zero  = ex_is_div & (md.ex_rs2 == '0);
    assign div_overflow = ex_is_div & ~md.ex_op[0] &
                          (md.ex_rs1 == INT_MIN) & (md.ex_rs2 == ALL_ONES);
    assign unit_valid   = op_q[3] ? md.mulvalid : md.divvalid;
    assign cnt_last     = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE: begin
                if (md_req) begin
                    op_d = md.ex_op;
                    a_d  = md.ex_rs1;
                    b_d  = md.ex_rs2;
                    rd_d = md.ex_rd;
                    if (div_by_zero) begin
                        data_d  = md.ex_op[1] ? md.ex_rs1 : ALL_ONES;
                        state_d = S_DONE;
                    end else if (div_overflow) begin
                        data_d  = md.ex_op[1] ? '0 : INT_MIN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = md.flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // A flush that coincides with the result or the deadline has nothing left to drain.
                if (unit_valid) begin
                    data_d  = md.alu_out;
                    state_d = md.flush ? S_IDLE : S_DONE;
                end else if (cnt_last) begin
                    if (md.flush) begin
                        state_d = S_IDLE;
                    end else begin
                        terr_d  = 1'b1;
                        data_d  = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (md.flush) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (unit_valid | cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Latched op/operands stay on the ALU in every state so its output is stable at valid.
    assign md.alu_op      = op_q;
    assign md.alu_a       = a_q;
    assign md.alu_b       = b_q;
    assign md.mulstart    = (state_q == S_ISSUE) &  op_q[3];
    assign md.divstart    = (state_q == S_ISSUE) & ~op_q[3];
    assign md.stall       = ((state_q == S_IDLE)  & md_req) |
                            (state_q == S_ISSUE) |
                            (state_q == S_WAIT)  |
                            ((state_q == S_DRAIN) & md_req);
    assign md.wb_valid    = (state_q == S_DONE) & ~md.flush;
    assign md.wb_rd       = rd_q;
    assign md.wb_data     = data_q;
    assign md.timeout_err = terr_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural ALU/unit model, vector table, random ops and flush/timeout/reset sequences.
module tb_muldiv_seq;
    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 200;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    muldiv_seq_if bus();

    muldiv_seq #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clock (clock),
        .rst   (rst),
        .md    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // RISC-V M-extension result computed with plain arithmetic.
    function automatic logic [31:0] ref_model(input logic [6:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op[3]) begin
            case (op[1:0])
                2'd1:    p = 64'(sa * sb);
                2'd2:    p = 64'(sa * ub);
                default: p = 64'(ua * ub);
            endcase
            return (op[1:0] == 2'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Units return garbage on the cases the sequencer must never start.
    function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (!op[3] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 32'hBAD0_BAD0;
        return ref_model(op, a, b);
    endfunction

    int unit_lat  = 0;
    bit unit_hang = 1'b0;
    bit spur_mul  = 1'b0;
    bit spur_div  = 1'b0;
    int mul_rem   = -1;
    int div_rem   = -1;

    // Unit timing: valid appears unit_lat edges after the edge that samples start.
    always @(posedge clock) begin
        if (rst) begin
            mul_rem <= -1;
            div_rem <= -1;
        end else begin
            if (bus.mulstart && !unit_hang) mul_rem <= unit_lat;
            else if (mul_rem >= 0)          mul_rem <= mul_rem - 1;
            if (bus.divstart && !unit_hang) div_rem <= unit_lat;
            else if (div_rem >= 0)          div_rem <= div_rem - 1;
        end
    end

    assign bus.mulvalid = (mul_rem == 0) || spur_mul;
    assign bus.divvalid = (div_rem == 0) || spur_div;
    assign bus.alu_out  = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    int n_ms = 0;
    int n_ds = 0;
    int n_wb = 0;
    always @(negedge clock) begin
        if (bus.mulstart) n_ms++;
        if (bus.divstart) n_ds++;
        if (bus.wb_valid) n_wb++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.ex_valid = 1'b1;
        bus.ex_op    = op;
        bus.ex_rs1   = a;
        bus.ex_rs2   = b;
        bus.ex_rd    = rd;
    endtask

    // Presents one op like a stalled pipeline would and checks the writeback. Called at posedge+1.
    task automatic run_check(input string name, input logic [6:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input int lat,
                             input bit hang, input bit spur_en, input logic [31:0] exp_data,
                             input int exp_lat, input int exp_ms, input int exp_ds);
        bit got;
        int cyc, latency, stalls, ms, ds;
        logic [31:0] data;
        logic [4:0]  rd_seen;
        got = 1'b0; cyc = 0; latency = -1; stalls = 0; ms = 0; ds = 0;
        data = '0; rd_seen = '0;
        unit_lat  = lat;
        unit_hang = hang;
        drive(op, a, b, rd);
        while (!got && cyc < BUDGET) begin
            spur_mul = spur_en && !op[3] && ($urandom_range(0, 1) == 1);
            spur_div = spur_en &&  op[3] && ($urandom_range(0, 1) == 1);
            @(negedge clock);
            stalls += int'(bus.stall);
            ms     += int'(bus.mulstart);
            ds     += int'(bus.divstart);
            if (bus.wb_valid) begin
                got     = 1'b1;
                data    = bus.wb_data;
                rd_seen = bus.wb_rd;
                latency = cyc;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        bus.ex_valid = 1'b0;
        spur_mul = 1'b0;
        spur_div = 1'b0;
        check($sformatf("%s.data", name),    data,            exp_data);
        check($sformatf("%s.latency", name), 32'(latency),    32'(exp_lat));
        check($sformatf("%s.stall", name),   32'(stalls),     32'(exp_lat));
        check($sformatf("%s.rd", name),      32'(rd_seen),    32'(rd));
        check($sformatf("%s.mulstart", name), 32'(ms),        32'(exp_ms));
        check($sformatf("%s.divstart", name), 32'(ds),        32'(exp_ds));
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_ms;
        int          exp_ds;
    } vec_t;

    vec_t vecs[13];

    logic [6:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_rd;
    int          r_lat;
    bit          r_sc;
    int          wb0, ms0, ds0;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{7'h18, 32'd7,          32'd6,          4,  32'd42,         7,  1, 0};
        vecs[1]  = '{7'h1B, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2,  32'hFFFF_FFFE,  5,  1, 0};
        vecs[2]  = '{7'h10, 32'd100,        32'd0,          3,  32'hFFFF_FFFF,  1,  0, 0};
        vecs[3]  = '{7'h13, 32'd100,        32'd0,          3,  32'd100,        1,  0, 0};
        vecs[4]  = '{7'h10, 32'h8000_0000,  32'hFFFF_FFFF,  3,  32'h8000_0000,  1,  0, 0};
        vecs[5]  = '{7'h12, 32'h8000_0000,  32'hFFFF_FFFF,  3,  32'd0,          1,  0, 0};
        vecs[6]  = '{7'h11, 32'd20,         32'd3,          3,  32'd6,          6,  0, 1};
        vecs[7]  = '{7'h12, 32'hFFFF_FFF9,  32'd2,          1,  32'hFFFF_FFFF,  4,  0, 1};
        vecs[8]  = '{7'h1A, 32'hFFFF_FFFF,  32'd2,          0,  32'hFFFF_FFFF,  3,  1, 0};
        vecs[9]  = '{7'h19, 32'h8000_0000,  32'h8000_0000,  1,  32'h4000_0000,  4,  1, 0};
        vecs[10] = '{7'h11, 32'h8000_0000,  32'hFFFF_FFFF,  2,  32'd0,          5,  0, 1};
        vecs[11] = '{7'h13, 32'd5,          32'd0,          2,  32'd5,          1,  0, 0};
        vecs[12] = '{7'h18, 32'd3,          32'd5,          TIMEOUT - 1, 32'd15, TIMEOUT + 2, 1, 0};

        bus.ex_valid = 1'b0;
        bus.ex_op    = '0;
        bus.ex_rs1   = '0;
        bus.ex_rs2   = '0;
        bus.ex_rd    = '0;
        bus.flush    = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.alu_op",      32'(bus.alu_op),      32'h0F);
        check("reset.alu_a",       bus.alu_a,            32'd0);
        check("reset.alu_b",       bus.alu_b,            32'd0);
        check("reset.wb_data",     bus.wb_data,          32'd0);
        check("reset.wb_rd",       32'(bus.wb_rd),       32'd0);
        check("reset.strobes",     32'({bus.mulstart, bus.divstart, bus.wb_valid}), 32'd0);
        check("reset.stall",       32'(bus.stall),       32'd0);
        check("reset.timeout_err", 32'(bus.timeout_err), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                      vecs[i].lat, 1'b0, 1'b1, vecs[i].exp_data, vecs[i].exp_lat,
                      vecs[i].exp_ms, vecs[i].exp_ds);
        end
        check("vec.no_timeout_err", 32'(bus.timeout_err), 32'd0);

        // Non-mul/div op and stray valids in IDLE are ignored.
        wb0 = n_wb; ms0 = n_ms; ds0 = n_ds;
        drive(7'h05, 32'd1, 32'd0, 5'd9);
        spur_mul = 1'b1;
        spur_div = 1'b1;
        @(negedge clock);
        check("nonmd.stall", 32'(bus.stall), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        bus.ex_valid = 1'b0;
        spur_mul = 1'b0;
        spur_div = 1'b0;
        check("nonmd.events", 32'((n_wb - wb0) + (n_ms - ms0) + (n_ds - ds0)), 32'd0);

        // Flush in WAIT: no writeback, the divider result is drained.
        wb0 = n_wb; ds0 = n_ds;
        unit_lat = 5; unit_hang = 1'b0;
        drive(7'h11, 32'd20, 32'd3, 5'd4);
        repeat (3) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        bus.ex_valid = 1'b0;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        @(negedge clock);
        check("flush_wait.stall", 32'(bus.stall), 32'd0);
        repeat (8) @(posedge clock);
        #1;
        check("flush_wait.wb_valid", 32'(n_wb - wb0), 32'd0);
        check("flush_wait.divstart", 32'(n_ds - ds0), 32'd1);
        run_check("after_flush_wait", 7'h18, 32'd2, 32'd3, 5'd6, 2, 1'b0, 1'b0,
                  32'd6, 5, 1, 0);

        // Flush in ISSUE: pulse still goes out; next op stalls in DRAIN until the mul result lands.
        wb0 = n_wb;
        unit_lat = 4; unit_hang = 1'b0;
        drive(7'h18, 32'd9, 32'd9, 5'd7);
        @(posedge clock);
        #1;
        bus.flush = 1'b1;
        bus.ex_valid = 1'b0;
        @(negedge clock);
        check("flush_issue.mulstart", 32'(bus.mulstart), 32'd1);
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        run_check("drain_then_divu", 7'h11, 32'd9, 32'd2, 5'd3, 1, 1'b0, 1'b0,
                  32'd4, 9, 0, 1);
        check("flush_issue.wb_count", 32'(n_wb - wb0), 32'd1);

        // Flush in DONE suppresses the strobe.
        wb0 = n_wb;
        unit_lat = 1; unit_hang = 1'b0;
        drive(7'h18, 32'd4, 32'd4, 5'd8);
        repeat (4) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(negedge clock);
        check("flush_done.wb_valid", 32'(bus.wb_valid), 32'd0);
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("flush_done.wb_count", 32'(n_wb - wb0), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r_op  = 7'h10 | ($urandom_range(0, 1) == 1 ? 7'h08 : 7'h00) | 7'($urandom_range(0, 3));
            r_a   = pick_operand();
            r_b   = pick_operand();
            r_rd  = 5'($urandom);
            r_lat = $urandom_range(0, 8);
            r_sc  = !r_op[3] && (r_b == 32'd0 ||
                    (!r_op[0] && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF));
            run_check($sformatf("rand%0d", i), r_op, r_a, r_b, r_rd, r_lat, 1'b0, 1'b1,
                      ref_model(r_op, r_a, r_b), r_sc ? 1 : 3 + r_lat,
                      (!r_sc && r_op[3]) ? 1 : 0, (!r_sc && !r_op[3]) ? 1 : 0);
        end

        // Unit never answers: abandon after TIMEOUT wait cycles with a sticky error.
        run_check("timeout", 7'h18, 32'd7, 32'd7, 5'd11, 0, 1'b1, 1'b0,
                  32'd0, TIMEOUT + 2, 1, 0);
        check("timeout.err", 32'(bus.timeout_err), 32'd1);
        run_check("after_timeout", 7'h18, 32'd3, 32'd3, 5'd12, 1, 1'b0, 1'b0,
                  32'd9, 4, 1, 0);
        check("timeout.sticky", 32'(bus.timeout_err), 32'd1);

        // Reset mid-WAIT returns everything to reset values.
        unit_hang = 1'b1;
        drive(7'h18, 32'd5, 32'd5, 5'd13);
        repeat (4) @(posedge clock);
        #1;
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_wait.alu_op",      32'(bus.alu_op),      32'h0F);
        check("rst_wait.alu_a",       bus.alu_a,            32'd0);
        check("rst_wait.wb_rd",       32'(bus.wb_rd),       32'd0);
        check("rst_wait.stall",       32'(bus.stall),       32'd0);
        check("rst_wait.strobes",     32'({bus.mulstart, bus.divstart, bus.wb_valid}), 32'd0);
        check("rst_wait.timeout_err", 32'(bus.timeout_err), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        run_check("after_rst", 7'h18, 32'd2, 32'd3, 5'd14, 3, 1'b0, 1'b1,
                  32'd6, 6, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
